fan_run_scheduler: RTL and testbench

//  Run controller for the fan datapath: turns debounced button pulses and the fan-timer switches

---
 rtl/fan_run_scheduler_pkg.sv | 29 ++
 rtl/fan_off_timer.sv | 78 +++++++
 rtl/fan_run_scheduler.sv | 138 +++++++++++++
 tb/tb_fan_run_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fan_run_scheduler_pkg.sv
// Shared encodings and default constants for the fan run scheduler.
// Imported by the scheduler top and its off-timer.
package fan_run_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLEW = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam logic [1:0] LVL_OFF = 2'd0;
    localparam logic [1:0] LVL_1   = 2'd1;
    localparam logic [1:0] LVL_2   = 2'd2;
    localparam logic [1:0] LVL_3   = 2'd3;

    localparam logic [9:0] DEF_DUTY_L1   = 10'd300;
    localparam logic [9:0] DEF_DUTY_L2   = 10'd600;
    localparam logic [9:0] DEF_DUTY_L3   = 10'd900;
    localparam logic [9:0] DEF_RAMP_STEP = 10'd10;

    localparam logic [6:0] DEF_T_SW0 = 7'd10;
    localparam logic [6:0] DEF_T_SW1 = 7'd30;
    localparam logic [6:0] DEF_T_SW2 = 7'd60;

    localparam logic [3:0] PRESC_LAST = 4'd9;
    localparam logic [6:0] CSEC_MAX   = 7'd99;

endpackage

// File: rtl/fan_off_timer.sv
// Off-timer countdown in seconds/centiseconds, one centisecond per ten 1 ms ticks.
// Expire is a combinational pulse on the tick that reaches 00.00.
module fan_off_timer
    import fan_run_scheduler_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [6:0] i_load_sec,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_tick,
    output logic [6:0] o_sec,
    output logic [6:0] o_csec,
    output logic       o_active,
    output logic       o_expire
);

    logic [6:0] sec_q, sec_d;
    logic [6:0] csec_q, csec_d;
    logic [3:0] presc_q, presc_d;
    logic       active_q, active_d;
    logic       count;
    logic       dec;

    assign count    = active_q & i_enable & i_tick;
    assign dec      = count & (presc_q == PRESC_LAST);
    assign o_expire = dec & (sec_q == 7'd0) & (csec_q == 7'd1);

    always_comb begin
        sec_d    = sec_q;
        csec_d   = csec_q;
        presc_d  = presc_q;
        active_d = active_q;
        if (i_clear) begin
            sec_d    = 7'd0;
            csec_d   = 7'd0;
            presc_d  = 4'd0;
            active_d = 1'b0;
        end else if (i_load) begin
            sec_d    = i_load_sec;
            csec_d   = 7'd0;
            presc_d  = 4'd0;
            active_d = (i_load_sec != 7'd0);
        end else if (dec) begin
            presc_d = 4'd0;
            if (csec_q == 7'd0) begin
                csec_d = CSEC_MAX;
                sec_d  = sec_q - 7'd1;
            end else begin
                csec_d = csec_q - 7'd1;
            end
            if (o_expire)
                active_d = 1'b0;
        end else if (count) begin
            presc_d = presc_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sec_q    <= 7'd0;
            csec_q   <= 7'd0;
            presc_q  <= 4'd0;
            active_q <= 1'b0;
        end else begin
            sec_q    <= sec_d;
            csec_q   <= csec_d;
            presc_q  <= presc_d;
            active_q <= active_d;
        end
    end

    assign o_sec    = sec_q;
    assign o_csec   = csec_q;
    assign o_active = active_q;

endmodule

// File: rtl/fan_run_scheduler.sv
// Fan run controller: button-driven speed level, slewed PWM duty and timed auto-off.
// Duty and level are registered; the off-timer lives in fan_off_timer.
module fan_run_scheduler
    import fan_run_scheduler_pkg::*;
#(
    parameter logic [9:0] DUTY_L1   = DEF_DUTY_L1,
    parameter logic [9:0] DUTY_L2   = DEF_DUTY_L2,
    parameter logic [9:0] DUTY_L3   = DEF_DUTY_L3,
    parameter logic [9:0] RAMP_STEP = DEF_RAMP_STEP,
    parameter logic [6:0] T_SW0     = DEF_T_SW0,
    parameter logic [6:0] T_SW1     = DEF_T_SW1,
    parameter logic [6:0] T_SW2     = DEF_T_SW2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1ms,
    input  logic [4:0] i_button,
    input  logic [2:0] i_fansw,
    output logic [1:0] o_speed_level,
    output logic [9:0] o_duty,
    output logic       o_running,
    output logic       o_timer_active,
    output logic [6:0] o_remain_sec,
    output logic [6:0] o_remain_csec
);

    state_e     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [9:0] target_q, target_d;
    logic [9:0] duty_q, duty_d;

    logic       btn_off, btn_rearm;
    logic [1:0] btn_spd;
    logic [9:0] spd_duty, duty_step;
    logic [6:0] load_sec;
    logic       reached;
    logic       tmr_load, tmr_clear, tmr_en, tmr_expire;

    assign btn_off   = i_button[0];
    assign btn_spd   = btn_off     ? LVL_OFF :
                       i_button[3] ? LVL_3   :
                       i_button[2] ? LVL_2   :
                       i_button[1] ? LVL_1   : LVL_OFF;
    assign btn_rearm = i_button[4] & ~|i_button[3:0];

    assign spd_duty = (btn_spd == LVL_3) ? DUTY_L3 :
                      (btn_spd == LVL_2) ? DUTY_L2 : DUTY_L1;
    assign load_sec = i_fansw[2] ? T_SW2 :
                      i_fansw[1] ? T_SW1 :
                      i_fansw[0] ? T_SW0 : 7'd0;

    // Snap to target when within one step so the ramp never overshoots or wraps
    always_comb begin
        if (duty_q < target_q)
            duty_step = (target_q - duty_q <= RAMP_STEP) ? target_q
                                                         : duty_q + RAMP_STEP;
        else
            duty_step = (duty_q - target_q <= RAMP_STEP) ? target_q
                                                         : duty_q - RAMP_STEP;
    end
    assign reached = (duty_step == target_q);
    assign tmr_en  = (state_q == SLEW) || (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        target_d  = target_q;
        duty_d    = duty_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        unique case (state_q)
            IDLE, STOP: begin
                if (btn_spd != LVL_OFF) begin
                    level_d  = btn_spd;
                    target_d = spd_duty;
                    tmr_load = 1'b1;
                    state_d  = SLEW;
                end else if (state_q == STOP && i_tick_1ms) begin
                    duty_d = duty_step;
                    if (reached)
                        state_d = IDLE;
                end
            end
            SLEW, RUN: begin
                if (state_q == SLEW && i_tick_1ms)
                    duty_d = duty_step;
                if (btn_off || tmr_expire) begin
                    level_d   = LVL_OFF;
                    target_d  = 10'd0;
                    tmr_clear = 1'b1;
                    state_d   = STOP;
                end else if (btn_spd != LVL_OFF && btn_spd != level_q) begin
                    level_d  = btn_spd;
                    target_d = spd_duty;
                    state_d  = SLEW;
                end else begin
                    tmr_load = btn_rearm;
                    if (state_q == SLEW && i_tick_1ms && reached)
                        state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            level_q  <= LVL_OFF;
            target_q <= 10'd0;
            duty_q   <= 10'd0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            duty_q   <= duty_d;
        end
    end

    fan_off_timer u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_load_sec (load_sec),
        .i_clear    (tmr_clear),
        .i_enable   (tmr_en),
        .i_tick     (i_tick_1ms),
        .o_sec      (o_remain_sec),
        .o_csec     (o_remain_csec),
        .o_active   (o_timer_active),
        .o_expire   (tmr_expire)
    );

    assign o_speed_level = level_q;
    assign o_duty        = duty_q;
    assign o_running     = (state_q != IDLE);

endmodule

// File: tb/tb_fan_run_scheduler.sv
// Directed bench for fan_run_scheduler: ramps, priorities, off-timer expiry and re-arm.
// Inputs change #1 after the rising edge; outputs are checked at the same point.
module tb_fan_run_scheduler;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [4:0] btn;
    logic [2:0] fansw;
    logic [1:0] lvl;
    logic [9:0] duty;
    logic       running;
    logic       tactive;
    logic [6:0] rsec;
    logic [6:0] rcsec;

    int checks = 0;
    int errors = 0;

    fan_run_scheduler dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_tick_1ms     (tick),
        .i_button       (btn),
        .i_fansw        (fansw),
        .o_speed_level  (lvl),
        .o_duty         (duty),
        .o_running      (running),
        .o_timer_active (tactive),
        .o_remain_sec   (rsec),
        .o_remain_csec  (rcsec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        btn = b;
        cyc();
        btn = 5'd0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        btn   = 5'd0;
        fansw = 3'd0;
        repeat (3) cyc();
        chk("rst_lvl", lvl, 0);
        chk("rst_duty", duty, 0);
        chk("rst_run", running, 0);
        chk("rst_tact", tactive, 0);
        chk("rst_sec", rsec, 0);
        chk("rst_csec", rcsec, 0);
        rst_n = 1'b1;
        cyc();

        press(5'b10001);
        chk("idle_off_rearm_ignored", running, 0);

        press(5'b00010);
        chk("l1_lvl", lvl, 1);
        chk("l1_duty0", duty, 0);
        chk("l1_run", running, 1);
        chk("l1_tact", tactive, 0);
        ticks(1);
        chk("l1_duty10", duty, 10);
        ticks(28);
        chk("l1_duty290", duty, 290);
        ticks(1);
        chk("l1_duty300", duty, 300);
        ticks(5);
        chk("l1_hold", duty, 300);

        press(5'b01000);
        chk("l3_lvl", lvl, 3);
        ticks(59);
        chk("l3_duty890", duty, 890);
        ticks(1);
        chk("l3_duty900", duty, 900);
        press(5'b01000);
        chk("l3_same_btn", lvl, 3);

        press(5'b00010);
        chk("down_lvl", lvl, 1);
        ticks(59);
        chk("down_duty310", duty, 310);
        ticks(1);
        chk("down_duty300", duty, 300);
        ticks(5);
        chk("down_no_under", duty, 300);

        press(5'b01001);
        chk("offwins_lvl", lvl, 0);
        chk("offwins_run", running, 1);
        chk("offwins_duty", duty, 300);
        ticks(10);
        chk("stop_duty200", duty, 200);
        press(5'b01000);
        chk("stop_up_lvl", lvl, 3);
        chk("stop_up_duty", duty, 200);
        ticks(1);
        chk("stop_up_duty210", duty, 210);

        rst_n = 1'b0;
        repeat (3) cyc();
        chk("midrst_lvl", lvl, 0);
        chk("midrst_duty", duty, 0);
        chk("midrst_run", running, 0);
        rst_n = 1'b1;
        cyc();
        ticks(3);
        chk("post_rst_run", running, 0);
        chk("post_rst_duty", duty, 0);

        fansw = 3'b001;
        press(5'b00100);
        chk("t_lvl", lvl, 2);
        chk("t_sec", rsec, 10);
        chk("t_csec", rcsec, 0);
        chk("t_act", tactive, 1);
        ticks(10);
        chk("t_sec9", rsec, 9);
        chk("t_csec99", rcsec, 99);
        ticks(9989);
        chk("t_pre_sec", rsec, 0);
        chk("t_pre_csec", rcsec, 1);
        chk("t_pre_lvl", lvl, 2);
        chk("t_pre_duty", duty, 600);
        ticks(1);
        chk("t_exp_lvl", lvl, 0);
        chk("t_exp_act", tactive, 0);
        chk("t_exp_csec", rcsec, 0);
        chk("t_exp_run", running, 1);
        chk("t_exp_duty", duty, 600);
        ticks(59);
        chk("t_ramp_duty10", duty, 10);
        ticks(1);
        chk("t_ramp_duty0", duty, 0);
        chk("t_idle", running, 0);

        press(5'b00010);
        chk("re_sec", rsec, 10);
        ticks(5000);
        chk("re_sec5", rsec, 5);
        chk("re_csec0", rcsec, 0);
        fansw = 3'b110;
        cyc();
        chk("re_noreload", rsec, 5);
        press(5'b10000);
        chk("re_reload_sec", rsec, 60);
        chk("re_reload_csec", rcsec, 0);
        chk("re_reload_act", tactive, 1);
        ticks(10);
        chk("re_sec59", rsec, 59);
        chk("re_csec99", rcsec, 99);
        fansw = 3'b000;
        press(5'b10000);
        chk("re_zero_act", tactive, 0);
        chk("re_zero_sec", rsec, 0);
        chk("re_zero_lvl", lvl, 1);

        press(5'b00001);
        chk("fin_lvl", lvl, 0);
        ticks(30);
        chk("fin_duty", duty, 0);
        chk("fin_idle", running, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
